// File: rtl/pgm_shaper.sv
// pgm_shaper: token-bucket egress shaper between pgm and goe.
// Each packet is stored whole, together with its PHV. It is released downstream
// only when the byte-credit bucket covers its length. Packets flagged invalid
// are discarded without costing credit.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_shp_data/_wr             134-bit flits ([133:132] 01 head/11 body/10 tail,
//                               [131:128] invalid tail bytes, [127:0] payload)
//   in_shp_valid/_wr            packet status, coincident with the tail flit
//   in_shp_phv/_wr              1024-bit PHV, one per packet
//   out_shp_alf/out_shp_phv_alf almost-full back-pressure to pgm
//   out_shp_data/_wr, out_shp_valid/_wr, out_shp_phv/_wr   traffic to goe
//   in_shp_alf/in_shp_phv_alf   goe almost-full, sampled only before a release
//   cfg_shp_en/rate/burst       shaping enable, bytes per cycle, bucket cap
//   out_shp_ovf                 sticky: a write hit a full FIFO
// Optional macro SHP_STAT_EN adds out_shp_pkt_cnt / out_shp_drop_cnt.
//
// state     | meaning
// IDLE      | wait for a complete packet (descriptor + PHV)
// CHECK     | drop if invalid, else wait for credit and downstream room
// SEND_PHV  | emit the PHV
// SEND_DATA | emit one flit per cycle through the tail
// DROP      | discard flits through the tail, retire PHV and descriptor
module pgm_shaper #(
  parameter int DEPTH_LOG2 = 9,
  parameter int ALF_MARGIN = 130,
  parameter int DESC_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_shp_data_wr,
  input  logic [133:0]  in_shp_data,
  input  logic          in_shp_valid_wr,
  input  logic          in_shp_valid,
  output logic          out_shp_alf,
  input  logic [1023:0] in_shp_phv,
  input  logic          in_shp_phv_wr,
  output logic          out_shp_phv_alf,
  output logic [133:0]  out_shp_data,
  output logic          out_shp_data_wr,
  output logic          out_shp_valid,
  output logic          out_shp_valid_wr,
  output logic [1023:0] out_shp_phv,
  output logic          out_shp_phv_wr,
  input  logic          in_shp_alf,
  input  logic          in_shp_phv_alf,
  input  logic          cfg_shp_en,
  input  logic [15:0]   cfg_shp_rate,
  input  logic [23:0]   cfg_shp_burst,
  output logic          out_shp_ovf
`ifdef SHP_STAT_EN
  , output logic [31:0] out_shp_pkt_cnt,
  output logic [31:0]   out_shp_drop_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DL    = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, SEND_PHV, SEND_DATA, DROP} state_t;
  state_t state, state_next;

  // data FIFO
  logic [133:0]          dmem [DEPTH];
  logic [DEPTH_LOG2-1:0] d_wp, d_rp;
  logic [DEPTH_LOG2:0]   d_cnt;
  logic                  d_full, d_empty, d_push, d_pop;
  logic [133:0]          rd_flit;
  logic                  rd_tail;

  // descriptor and PHV FIFOs share depth and pointer width
  logic [16:0]   desc_mem [DESC_DEPTH];
  logic [1023:0] phv_mem  [DESC_DEPTH];
  logic [DL-1:0] desc_wp, desc_rp, phv_wp, phv_rp;
  logic [DL:0]   desc_cnt, phv_cnt;
  logic          desc_full, desc_empty, desc_push_req, desc_push, desc_pop;
  logic          phv_full, phv_empty, phv_push, phv_pop;
  logic          desc_valid;
  logic [15:0]   desc_hlen;

  logic [15:0] len_acc, pkt_len;
  logic        in_tail;

  logic [23:0] tokens, tokens_next;
  logic [25:0] tok_sum;
  logic        debit, emit_phv, emit_flit, emit_tail, drop_done;

  function automatic logic [DL-1:0] ptr_inc(input logic [DL-1:0] p);
    return (p == DL'(DESC_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign d_full     = (d_cnt == (DEPTH_LOG2+1)'(DEPTH));
  assign d_empty    = (d_cnt == '0);
  assign desc_full  = (desc_cnt == (DL+1)'(DESC_DEPTH));
  assign desc_empty = (desc_cnt == '0);
  assign phv_full   = (phv_cnt == (DL+1)'(DESC_DEPTH));
  assign phv_empty  = (phv_cnt == '0);

  assign in_tail       = (in_shp_data[133:132] == 2'b10);
  assign pkt_len       = len_acc + 16'd16 - {12'b0, in_shp_data[131:128]};
  assign d_push        = in_shp_data_wr & ~d_full;
  assign desc_push_req = in_shp_data_wr & in_tail & in_shp_valid_wr;
  assign desc_push     = desc_push_req & ~desc_full;
  assign phv_push      = in_shp_phv_wr & ~phv_full;

  assign rd_flit    = dmem[d_rp];
  assign rd_tail    = (rd_flit[133:132] == 2'b10);
  assign desc_valid = desc_mem[desc_rp][16];
  assign desc_hlen  = desc_mem[desc_rp][15:0];

  always_comb begin
    state_next = state;
    debit      = 1'b0;
    emit_phv   = 1'b0;
    emit_flit  = 1'b0;
    emit_tail  = 1'b0;
    drop_done  = 1'b0;
    d_pop      = 1'b0;
    desc_pop   = 1'b0;
    phv_pop    = 1'b0;
    case (state)
      IDLE: if (!desc_empty && !phv_empty) state_next = CHECK;
      CHECK: begin
        if (!desc_valid) begin
          state_next = DROP;
        end else if ((tokens >= {8'b0, desc_hlen} || !cfg_shp_en) &&
                     !in_shp_alf && !in_shp_phv_alf) begin
          state_next = SEND_PHV;
          debit      = 1'b1;
        end
      end
      SEND_PHV: begin
        phv_pop    = 1'b1;
        emit_phv   = 1'b1;
        state_next = SEND_DATA;
      end
      SEND_DATA: begin
        // the whole packet is already stored, so empty only guards a
        // packet that lost flits to overflow
        if (!d_empty) begin
          d_pop     = 1'b1;
          emit_flit = 1'b1;
          if (rd_tail) begin
            emit_tail  = 1'b1;
            desc_pop   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DROP: begin
        if (!d_empty) begin
          d_pop = 1'b1;
          if (rd_tail) begin
            phv_pop    = 1'b1;
            desc_pop   = 1'b1;
            drop_done  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // debit never exceeds tokens while shaping, so the sum cannot go negative
  always_comb begin
    tok_sum     = {2'b00, tokens} + {10'b0, cfg_shp_rate} -
                  (debit ? {10'b0, desc_hlen} : 26'd0);
    tokens_next = (tok_sum > {2'b00, cfg_shp_burst}) ? cfg_shp_burst : tok_sum[23:0];
    if (!cfg_shp_en) tokens_next = cfg_shp_burst;
  end

  always_ff @(posedge clk) begin
    if (d_push)    dmem[d_wp]        <= in_shp_data;
    if (desc_push) desc_mem[desc_wp] <= {in_shp_valid, pkt_len};
    if (phv_push)  phv_mem[phv_wp]   <= in_shp_phv;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      tokens           <= cfg_shp_burst;
      d_wp             <= '0;
      d_rp             <= '0;
      d_cnt            <= '0;
      desc_wp          <= '0;
      desc_rp          <= '0;
      desc_cnt         <= '0;
      phv_wp           <= '0;
      phv_rp           <= '0;
      phv_cnt          <= '0;
      len_acc          <= '0;
      out_shp_data     <= '0;
      out_shp_data_wr  <= 1'b0;
      out_shp_valid    <= 1'b0;
      out_shp_valid_wr <= 1'b0;
      out_shp_phv      <= '0;
      out_shp_phv_wr   <= 1'b0;
      out_shp_alf      <= 1'b0;
      out_shp_phv_alf  <= 1'b0;
      out_shp_ovf      <= 1'b0;
    end else begin
      state  <= state_next;
      tokens <= tokens_next;

      if (in_shp_data_wr) len_acc <= in_tail ? 16'd0 : len_acc + 16'd16;

      if (d_push) d_wp <= d_wp + 1'b1;
      if (d_pop)  d_rp <= d_rp + 1'b1;
      case ({d_push, d_pop})
        2'b10:   d_cnt <= d_cnt + 1'b1;
        2'b01:   d_cnt <= d_cnt - 1'b1;
        default: ;
      endcase

      if (desc_push) desc_wp <= ptr_inc(desc_wp);
      if (desc_pop)  desc_rp <= ptr_inc(desc_rp);
      case ({desc_push, desc_pop})
        2'b10:   desc_cnt <= desc_cnt + 1'b1;
        2'b01:   desc_cnt <= desc_cnt - 1'b1;
        default: ;
      endcase

      if (phv_push) phv_wp <= ptr_inc(phv_wp);
      if (phv_pop)  phv_rp <= ptr_inc(phv_rp);
      case ({phv_push, phv_pop})
        2'b10:   phv_cnt <= phv_cnt + 1'b1;
        2'b01:   phv_cnt <= phv_cnt - 1'b1;
        default: ;
      endcase

      out_shp_alf     <= ((DEPTH - int'(d_cnt)) < ALF_MARGIN) ||
                         (int'(desc_cnt) >= DESC_DEPTH - 2);
      out_shp_phv_alf <= (int'(phv_cnt) >= DESC_DEPTH - 2);
      if ((in_shp_data_wr && d_full) || (desc_push_req && desc_full) ||
          (in_shp_phv_wr && phv_full))
        out_shp_ovf <= 1'b1;

      out_shp_phv_wr   <= emit_phv;
      if (emit_phv) out_shp_phv <= phv_mem[phv_rp];
      out_shp_data_wr  <= emit_flit;
      if (emit_flit) out_shp_data <= rd_flit;
      out_shp_valid_wr <= emit_tail;
      out_shp_valid    <= emit_tail;
    end
  end

`ifdef SHP_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_shp_pkt_cnt  <= '0;
      out_shp_drop_cnt <= '0;
    end else begin
      if (emit_tail) out_shp_pkt_cnt  <= out_shp_pkt_cnt + 32'd1;
      if (drop_done) out_shp_drop_cnt <= out_shp_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pgm_shaper.sv
module tb_pgm_shaper;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_shp_data_wr = 1'b0;
  logic [133:0]  in_shp_data = '0;
  logic          in_shp_valid_wr = 1'b0;
  logic          in_shp_valid = 1'b0;
  logic          out_shp_alf;
  logic [1023:0] in_shp_phv = '0;
  logic          in_shp_phv_wr = 1'b0;
  logic          out_shp_phv_alf;
  logic [133:0]  out_shp_data;
  logic          out_shp_data_wr;
  logic          out_shp_valid;
  logic          out_shp_valid_wr;
  logic [1023:0] out_shp_phv;
  logic          out_shp_phv_wr;
  logic          in_shp_alf = 1'b0;
  logic          in_shp_phv_alf = 1'b0;
  logic          cfg_shp_en = 1'b0;
  logic [15:0]   cfg_shp_rate = 16'd1;
  logic [23:0]   cfg_shp_burst = 24'd64;
  logic          out_shp_ovf;
`ifdef SHP_STAT_EN
  logic [31:0]   out_shp_pkt_cnt;
  logic [31:0]   out_shp_drop_cnt;
`endif

  pgm_shaper dut (
    .clk(clk), .rst(rst),
    .in_shp_data_wr(in_shp_data_wr), .in_shp_data(in_shp_data),
    .in_shp_valid_wr(in_shp_valid_wr), .in_shp_valid(in_shp_valid),
    .out_shp_alf(out_shp_alf),
    .in_shp_phv(in_shp_phv), .in_shp_phv_wr(in_shp_phv_wr),
    .out_shp_phv_alf(out_shp_phv_alf),
    .out_shp_data(out_shp_data), .out_shp_data_wr(out_shp_data_wr),
    .out_shp_valid(out_shp_valid), .out_shp_valid_wr(out_shp_valid_wr),
    .out_shp_phv(out_shp_phv), .out_shp_phv_wr(out_shp_phv_wr),
    .in_shp_alf(in_shp_alf), .in_shp_phv_alf(in_shp_phv_alf),
    .cfg_shp_en(cfg_shp_en), .cfg_shp_rate(cfg_shp_rate),
    .cfg_shp_burst(cfg_shp_burst),
    .out_shp_ovf(out_shp_ovf)
`ifdef SHP_STAT_EN
    , .out_shp_pkt_cnt(out_shp_pkt_cnt), .out_shp_drop_cnt(out_shp_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [1023:0] exp_phv [$];
  logic [133:0]  exp_flit [$];
  int            phv_t [$];
  int            tail_t [$];
  int            tin [$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: sampled 1 time unit after the rising edge; cyc is then the edge number
  logic [1023:0] mon_phv;
  logic [133:0]  mon_flit;
  logic          mon_tail;
  always @(posedge clk) begin
    #1;
    if (out_shp_phv_wr) begin
      phv_t.push_back(cyc);
      n_cmp++;
      if (exp_phv.size() == 0) begin
        n_err++;
        $display("FAIL phv_unexpected: got %h expected none", out_shp_phv[127:0]);
      end else begin
        mon_phv = exp_phv.pop_front();
        if (out_shp_phv !== mon_phv) begin
          n_err++;
          $display("FAIL phv_value: got %h expected %h", out_shp_phv[127:0], mon_phv[127:0]);
        end
      end
    end
    if (out_shp_data_wr) begin
      mon_tail = (out_shp_data[133:132] == 2'b10);
      if (mon_tail) tail_t.push_back(cyc);
      n_cmp++;
      if (exp_flit.size() == 0) begin
        n_err++;
        $display("FAIL flit_unexpected: got %h expected none", out_shp_data);
      end else begin
        mon_flit = exp_flit.pop_front();
        if (out_shp_data !== mon_flit) begin
          n_err++;
          $display("FAIL flit_value: got %h expected %h", out_shp_data, mon_flit);
        end
      end
      n_cmp++;
      if ({out_shp_valid_wr, out_shp_valid} !== (mon_tail ? 2'b11 : 2'b00)) begin
        n_err++;
        $display("FAIL valid_strobe: got %b expected %b", {out_shp_valid_wr, out_shp_valid},
                 mon_tail ? 2'b11 : 2'b00);
      end
    end else if (out_shp_valid_wr) begin
      n_cmp++;
      n_err++;
      $display("FAIL valid_wr_alone: got 1 expected 0");
    end
  end

  task automatic idle_in();
    @(negedge clk);
    in_shp_data_wr  = 1'b0;
    in_shp_valid_wr = 1'b0;
    in_shp_valid    = 1'b0;
    in_shp_phv_wr   = 1'b0;
  endtask

  task automatic send_pkt(input int id, input int nfl, input int inval, input bit good);
    logic [1:0]  t;
    logic [31:0] w;
    for (int i = 0; i < nfl; i++) begin
      @(negedge clk);
      t = (i == 0) ? 2'b01 : ((i == nfl - 1) ? 2'b10 : 2'b11);
      w = 32'(id * 256 + i);
      in_shp_data_wr  = 1'b1;
      in_shp_data     = {t, (i == nfl - 1) ? 4'(inval) : 4'd0, {4{w}}};
      in_shp_phv_wr   = (i == 0);
      in_shp_phv      = {32{32'(id)}};
      in_shp_valid_wr = (i == nfl - 1);
      in_shp_valid    = (i == nfl - 1) && good;
      if (good && i == 0) exp_phv.push_back(in_shp_phv);
      if (good) exp_flit.push_back(in_shp_data);
      if (i == nfl - 1) tin.push_back(cyc + 1);
    end
  endtask

  task automatic write_raw(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_shp_data_wr = 1'b1;
      in_shp_data    = {2'b11, 4'd0, 128'(i)};
    end
  endtask

  task automatic wait_phv(input int n, input int budget, input string nm);
    int k = 0;
    while (phv_t.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, phv_t.size(), n);
  endtask

  task automatic wait_tail(input int n, input int budget, input string nm);
    int k = 0;
    while (tail_t.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, tail_t.size(), n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_shp_data_wr = 1'b0; in_shp_valid_wr = 1'b0; in_shp_phv_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_phv.delete(); exp_flit.delete();
    phv_t.delete(); tail_t.delete(); tin.delete();
  endtask

  task automatic end_test(input string nm);
    repeat (10) @(negedge clk);
    chk({nm, "_exp_phv_left"}, exp_phv.size(), 0);
    chk({nm, "_exp_flit_left"}, exp_flit.size(), 0);
  endtask

  function automatic logic all_out_zero();
    return out_shp_data == '0 && out_shp_phv == '0 && !out_shp_data_wr && !out_shp_phv_wr &&
           !out_shp_valid_wr && !out_shp_valid && !out_shp_alf && !out_shp_phv_alf && !out_shp_ovf;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  int rel;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out_zero(), 1);
    rst = 1'b0;

    // 1: shaping off, three 64B packets back-to-back
    cfg_shp_en = 1'b0;
    do_reset();
    send_pkt(1, 4, 0, 1); send_pkt(2, 4, 0, 1); send_pkt(3, 4, 0, 1);
    idle_in();
    wait_phv(3, 200, "t1_phv_count");
    wait_tail(3, 200, "t1_tail_count");
    if (phv_t.size() >= 3 && tail_t.size() >= 3) begin
      chk("t1_latency", phv_t[0] - tin[0], 3);
      for (int i = 0; i < 3; i++) chk("t1_flits_b2b", tail_t[i] - phv_t[i], 4);
      for (int i = 0; i < 2; i++) chk("t1_gap", phv_t[i+1] - tail_t[i], 3);
    end
    end_test("t1");

    // 2: rate 1 B/cycle, burst 64
    cfg_shp_en = 1'b1; cfg_shp_rate = 16'd1; cfg_shp_burst = 24'd64;
    do_reset();
    send_pkt(4, 4, 0, 1); send_pkt(5, 4, 0, 1); send_pkt(6, 4, 0, 1);
    idle_in();
    wait_phv(3, 400, "t2_phv_count");
    wait_tail(3, 50, "t2_tail_count");
    if (phv_t.size() >= 3) begin
      chk("t2_latency", phv_t[0] - tin[0], 3);
      chk("t2_space_1", phv_t[1] - phv_t[0], 64);
      chk("t2_space_2", phv_t[2] - phv_t[1], 64);
    end
    end_test("t2");

    // 3: invalid 128B packet between two valid ones
    do_reset();
    send_pkt(7, 4, 0, 1); send_pkt(8, 8, 0, 0); send_pkt(9, 4, 0, 1);
    idle_in();
    wait_phv(2, 400, "t3_phv_count");
    wait_tail(2, 50, "t3_tail_count");
    if (phv_t.size() >= 2) chk("t3_no_debit_on_drop", phv_t[1] - phv_t[0], 64);
    repeat (20) @(negedge clk);
    chk("t3_only_two_out", tail_t.size(), 2);
`ifdef SHP_STAT_EN
    chk("t3_drop_cnt", out_shp_drop_cnt, 1);
    chk("t3_pkt_cnt", out_shp_pkt_cnt, 2);
`endif
    end_test("t3");

    // 4: downstream almost-full
    cfg_shp_en = 1'b0;
    do_reset();
    in_shp_alf = 1'b1;
    send_pkt(10, 4, 5, 1);
    idle_in();
    repeat (20) @(negedge clk);
    chk("t4_held_by_alf", phv_t.size(), 0);
    @(negedge clk);
    in_shp_alf = 1'b0;
    rel = cyc;
    wait_phv(1, 50, "t4_phv_after_release");
    in_shp_alf = 1'b1;
    if (phv_t.size() >= 1) chk("t4_release_latency", phv_t[0] - rel, 2);
    wait_tail(1, 50, "t4_tail_count");
    if (phv_t.size() >= 1 && tail_t.size() >= 1)
      chk("t4_no_stall_in_send", tail_t[0] - phv_t[0], 4);
    in_shp_alf = 1'b0;
    end_test("t4");

    // 5: fill data FIFO, almost-full threshold and overflow
    do_reset();
    write_raw(382); idle_in(); repeat (2) @(negedge clk);
    chk("t5_alf_at_382", out_shp_alf, 0);
    write_raw(1); idle_in(); repeat (2) @(negedge clk);
    chk("t5_alf_at_383", out_shp_alf, 1);
    chk("t5_no_ovf_383", out_shp_ovf, 0);
    write_raw(129); idle_in(); repeat (2) @(negedge clk);
    chk("t5_no_ovf_512", out_shp_ovf, 0);
    write_raw(1); idle_in(); repeat (2) @(negedge clk);
    chk("t5_ovf_set", out_shp_ovf, 1);
    repeat (10) @(negedge clk);
    chk("t5_ovf_sticky", out_shp_ovf, 1);
    do_reset();
    chk("t5_ovf_cleared", out_shp_ovf, 0);
    chk("t5_alf_cleared", out_shp_alf, 0);

    // 6: reset in the middle of SEND_DATA
    send_pkt(11, 4, 0, 1);
    idle_in();
    wait_phv(1, 50, "t6_phv_seen");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_outputs_zero", all_out_zero(), 1);
    chk("t6_no_tail", tail_t.size(), 0);
    do_reset();
    send_pkt(12, 4, 3, 1);
    idle_in();
    wait_phv(1, 50, "t6_phv_after");
    wait_tail(1, 50, "t6_tail_after");
    if (phv_t.size() >= 1 && tail_t.size() >= 1) begin
      chk("t6_latency", phv_t[0] - tin[0], 3);
      chk("t6_flits_b2b", tail_t[0] - phv_t[0], 4);
    end
    end_test("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
